// File: rtl/spike_packetizer.sv
// ---------------------------------------------------------------------------
// spike_packetizer
//
// Fan-out stage between the neuron array and the NoC router port. Spikes are
// latched into a pending bitmap for the current timestep; each pending neuron
// is served once, walking its CSR row one downstream connection per cycle and
// emitting {source address, destination address} over valid/ready.
//
// Optional feature macro: SPIKE_PKT_STATS_EN (adds pkt_count, an accepted
// packet counter that saturates at 16'hFFFF and is zeroed by clear/reset).
//
// Ports:
//   CLK, RESET_N                          clock (rising) / async active-low reset
//   clear                                 synchronous timestep start pulse
//   spike_in                              per-neuron spike flags
//   neuron_addresses_initialization       static address table, slice i = neuron i
//   connection_pointer_initialization     static CSR row pointers (NUM_NEURONS+1)
//   downstream_connections_initialization static destination table
//   pkt_valid / pkt_ready / pkt_data      packet handshake, data = {src, dst}
//   busy                                  pending spikes or fan-out in progress
//   timestep_done                         one-cycle pulse when all work drained
//   pkt_count                             accepted packets (stats build only)
//
// state | meaning
// IDLE  | pick lowest pending neuron and load its CSR row bounds
// EMIT  | present dc[ptr]; advance on acceptance until the row end
// ---------------------------------------------------------------------------
module spike_packetizer #(
    parameter int NUM_NEURONS     = 10,
    parameter int ADDR_BITS       = 12,
    parameter int MAX_CONNECTIONS = 30,
    parameter int PTR_BITS        = 5
) (
    input  logic                                  CLK,
    input  logic                                  RESET_N,
    input  logic                                  clear,
    input  logic [NUM_NEURONS-1:0]                spike_in,
    input  logic [ADDR_BITS*NUM_NEURONS-1:0]      neuron_addresses_initialization,
    input  logic [(NUM_NEURONS+1)*PTR_BITS-1:0]   connection_pointer_initialization,
    input  logic [ADDR_BITS*MAX_CONNECTIONS-1:0]  downstream_connections_initialization,
    output logic                                  pkt_valid,
    input  logic                                  pkt_ready,
    output logic [2*ADDR_BITS-1:0]                pkt_data,
    output logic                                  busy,
    output logic                                  timestep_done
`ifdef SPIKE_PKT_STATS_EN
    ,
    output logic [15:0]                           pkt_count
`endif
);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_EMIT = 1'b1;

    localparam int                  IDX_BITS = $clog2(NUM_NEURONS + 1);
    localparam logic [IDX_BITS-1:0] IDX_ONE  = IDX_BITS'(1);
    localparam logic [PTR_BITS-1:0] PTR_ONE  = PTR_BITS'(1);
    localparam logic [PTR_BITS-1:0] PTR_MAX  = PTR_BITS'(MAX_CONNECTIONS);

    logic [ADDR_BITS-1:0] addr_tbl [NUM_NEURONS];
    logic [PTR_BITS-1:0]  cp_tbl   [NUM_NEURONS+1];
    logic [ADDR_BITS-1:0] dc_tbl   [MAX_CONNECTIONS];

    always_comb begin
        for (int i = 0; i < NUM_NEURONS; i++)
            addr_tbl[i] = neuron_addresses_initialization[i*ADDR_BITS +: ADDR_BITS];
        for (int i = 0; i <= NUM_NEURONS; i++)
            cp_tbl[i] = connection_pointer_initialization[i*PTR_BITS +: PTR_BITS];
        for (int j = 0; j < MAX_CONNECTIONS; j++)
            dc_tbl[j] = downstream_connections_initialization[j*ADDR_BITS +: ADDR_BITS];
    end

    logic [0:0]             state_q, state_d;
    logic [NUM_NEURONS-1:0] pending_q, pending_d;
    logic [NUM_NEURONS-1:0] served_q, served_d;
    logic [IDX_BITS-1:0]    cur_q, cur_d;
    logic [PTR_BITS-1:0]    ptr_q, ptr_d;
    logic [PTR_BITS-1:0]    end_q, end_d;
    logic                   dirty_q, dirty_d;

    logic [IDX_BITS-1:0]    sel_idx;
    logic [PTR_BITS-1:0]    sel_start;
    logic [PTR_BITS-1:0]    sel_next;
    logic [PTR_BITS-1:0]    sel_end;

    // Lowest pending index wins.
    always_comb begin
        sel_idx = '0;
        for (int i = NUM_NEURONS - 1; i >= 0; i--)
            if (pending_q[i]) sel_idx = IDX_BITS'(i);
        sel_start = cp_tbl[sel_idx];
        sel_next  = cp_tbl[sel_idx + IDX_ONE];
        sel_end   = (sel_next > PTR_MAX) ? PTR_MAX : sel_next;
    end

    assign pkt_valid     = (state_q == ST_EMIT);
    assign pkt_data      = pkt_valid ? {addr_tbl[cur_q], dc_tbl[ptr_q]} : '0;
    assign busy          = pkt_valid | (|pending_q);
    // dirty_q records that served grew since the last pulse or clear.
    assign timestep_done = (state_q == ST_IDLE) & ~(|pending_q) & dirty_q;

    always_comb begin
        state_d   = state_q;
        pending_d = pending_q | (spike_in & ~served_q & ~pending_q);
        served_d  = served_q;
        cur_d     = cur_q;
        ptr_d     = ptr_q;
        end_d     = end_q;
        dirty_d   = dirty_q & ~timestep_done;

        case (state_q)
            ST_IDLE: begin
                if (|pending_q) begin
                    pending_d[sel_idx] = 1'b0;
                    served_d[sel_idx]  = 1'b1;
                    dirty_d            = 1'b1;
                    cur_d              = sel_idx;
                    ptr_d              = sel_start;
                    end_d              = sel_end;
                    // A reversed or empty row falls out here as zero fan-out.
                    if (sel_start < sel_end) state_d = ST_EMIT;
                end
            end
            default: begin
                if (pkt_ready) begin
                    ptr_d = ptr_q + PTR_ONE;
                    if (ptr_q + PTR_ONE == end_q) state_d = ST_IDLE;
                end
            end
        endcase

        if (clear) begin
            state_d   = ST_IDLE;
            pending_d = '0;
            served_d  = '0;
            ptr_d     = '0;
            dirty_d   = 1'b0;
        end
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q   <= ST_IDLE;
            pending_q <= '0;
            served_q  <= '0;
            cur_q     <= '0;
            ptr_q     <= '0;
            end_q     <= '0;
            dirty_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            pending_q <= pending_d;
            served_q  <= served_d;
            cur_q     <= cur_d;
            ptr_q     <= ptr_d;
            end_q     <= end_d;
            dirty_q   <= dirty_d;
        end
    end

`ifdef SPIKE_PKT_STATS_EN
    logic [15:0] cnt_q;

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            cnt_q <= '0;
        end else if (clear) begin
            cnt_q <= '0;
        end else if (pkt_valid && pkt_ready && (cnt_q != 16'hFFFF)) begin
            cnt_q <= cnt_q + 16'd1;
        end
    end

    assign pkt_count = cnt_q;
`endif

endmodule
